// File: rtl/rect_commutation_ctrl.sv
// rect_commutation_ctrl: sequences rectifier sector/judge updates inside inverter zero vectors with SD blanking.
// Optional RECT_COMM_WATCHDOG_EN faults the block if no zero vector arrives within WD_CYCLES.
module rect_commutation_ctrl #(
  parameter int DEAD_CYCLES = 8,
  parameter int CNT_W       = 16,
  parameter int WD_CYCLES   = 1000
) (
  input  logic             sysclk,
  input  logic             global_rst,
  input  logic             enable,
  input  logic             fault_in,
  input  logic             fault_clr,
  input  logic [15:0]      sector_req,
  input  logic             judge_req,
  input  logic             inv_zero_vec,
  output logic [15:0]      grid_sector,
  output logic             grid_judge,
  output logic             SD,
  output logic             busy,
  output logic             fault,
  output logic             sector_err,
  output logic [CNT_W-1:0] comm_cnt
);
  typedef enum logic [2:0] {S_OFF, S_RUN, S_WAIT, S_BLANK, S_LOAD, S_FAULT} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_dead;
  logic [15:0] r_pend_sector;
  logic        r_pend_judge;
  logic        w_valid, w_same, w_err, w_wd_trip;
  assign w_valid = (sector_req >= 16'd1) && (sector_req <= 16'd6);
  assign w_same  = (sector_req == grid_sector) && (judge_req == grid_judge);
`ifdef RECT_COMM_WATCHDOG_EN
  localparam int WW = $clog2(WD_CYCLES + 1);
  logic [WW-1:0] r_wait;
  assign w_wd_trip = r_wait == WW'(WD_CYCLES - 1);
  always_ff @(posedge sysclk or posedge global_rst)
    if (global_rst) r_wait <= '0;
    else            r_wait <= (r_state == S_WAIT && w_next == S_WAIT) ? r_wait + WW'(1) : '0;
`else
  assign w_wd_trip = 1'b0;
  if (WD_CYCLES < 1) begin : g_wd_unused
  end
`endif
  // Priority: fault, then latched fault clear, then disable, then sequencing.
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    if (fault_in) w_next = S_FAULT;
    else if (r_state == S_FAULT) w_next = fault_clr ? S_OFF : S_FAULT;
    else if (!enable) w_next = S_OFF;
    else
      case (r_state)
        S_OFF: begin
          w_next = (inv_zero_vec && w_valid) ? S_RUN : S_OFF;
          w_err  = inv_zero_vec && !w_valid;
        end
        S_RUN: begin
          w_next = (!w_same && w_valid) ? S_WAIT : S_RUN;
          w_err  = !w_same && !w_valid;
        end
        S_WAIT:  w_next = w_same ? S_RUN : (inv_zero_vec && w_valid) ? S_BLANK : w_wd_trip ? S_FAULT : S_WAIT;
        S_BLANK: w_next = (r_dead <= 8'd1) ? S_LOAD : S_BLANK;
        S_LOAD:  w_next = S_RUN;
        default: w_next = S_OFF;
      endcase
  end
  always_ff @(posedge sysclk or posedge global_rst) begin
    if (global_rst) begin
      r_state       <= S_OFF;
      r_dead        <= '0;
      r_pend_sector <= '0;
      r_pend_judge  <= 1'b0;
      grid_sector   <= '0;
      grid_judge    <= 1'b0;
      SD            <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
      sector_err    <= 1'b0;
      comm_cnt      <= '0;
    end else begin
      r_state    <= w_next;
      SD         <= w_next inside {S_RUN, S_WAIT};
      busy       <= w_next inside {S_WAIT, S_BLANK, S_LOAD};
      fault      <= w_next == S_FAULT;
      sector_err <= w_err;
      if (r_state == S_OFF && w_next == S_RUN) begin
        grid_sector <= sector_req;
        grid_judge  <= judge_req;
      end
      if (r_state == S_WAIT && w_next == S_BLANK) begin
        r_pend_sector <= sector_req;
        r_pend_judge  <= judge_req;
        r_dead        <= 8'(DEAD_CYCLES);
      end else if (r_state == S_BLANK) begin
        r_dead <= r_dead - 8'd1;
      end
      // New sector lands on entry to LOAD, so it changes only while SD is low.
      if (r_state == S_BLANK && w_next == S_LOAD) begin
        grid_sector <= r_pend_sector;
        grid_judge  <= r_pend_judge;
        comm_cnt    <= comm_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_rect_commutation_ctrl.sv
// tb_rect_commutation_ctrl: directed scenarios plus randomized run against a cycle-level behavioural model.
module tb_rect_commutation_ctrl;
  localparam int DEAD = 8;
  localparam int WD   = 20;
  localparam int OFF = 0, RUN = 1, WAITZ = 2, BLANK = 3, LOAD = 4, FLT = 5;
`ifdef RECT_COMM_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif
  logic        sysclk = 1'b0;
  logic        global_rst, enable, fault_in, fault_clr, judge_req, inv_zero_vec;
  logic [15:0] sector_req;
  logic [15:0] grid_sector;
  logic        grid_judge, SD, busy, fault, sector_err;
  logic [15:0] comm_cnt;
  int n_pass = 0, n_chk = 0;
  int m_mode, m_sec, m_jdg, m_pend_sec, m_pend_jdg, m_left, m_waited, m_cnt, m_err;

  rect_commutation_ctrl #(.DEAD_CYCLES(DEAD), .CNT_W(16), .WD_CYCLES(WD)) dut (
    .sysclk(sysclk), .global_rst(global_rst), .enable(enable), .fault_in(fault_in),
    .fault_clr(fault_clr), .sector_req(sector_req), .judge_req(judge_req),
    .inv_zero_vec(inv_zero_vec), .grid_sector(grid_sector), .grid_judge(grid_judge),
    .SD(SD), .busy(busy), .fault(fault), .sector_err(sector_err), .comm_cnt(comm_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic model_reset();
    m_mode = OFF; m_sec = 0; m_jdg = 0; m_pend_sec = 0; m_pend_jdg = 0;
    m_left = 0; m_waited = 0; m_cnt = 0; m_err = 0;
  endtask

  // One sysclk edge of the specified behaviour, evaluated from the inputs present before the edge.
  task automatic model_step();
    int nm = m_mode;
    bit valid = sector_req >= 1 && sector_req <= 6;
    bit same = (int'(sector_req) == m_sec) && (int'(judge_req) == m_jdg);
    m_err = 0;
    if (fault_in) nm = FLT;
    else if (m_mode == FLT) begin if (fault_clr) nm = OFF; end
    else if (!enable) nm = OFF;
    else if (m_mode == OFF) begin
      if (inv_zero_vec && valid) begin nm = RUN; m_sec = sector_req; m_jdg = judge_req; end
      else if (inv_zero_vec) m_err = 1;
    end else if (m_mode == RUN) begin
      if (!same && valid) nm = WAITZ;
      else if (!same) m_err = 1;
    end else if (m_mode == WAITZ) begin
      m_waited++;
      if (same) nm = RUN;
      else if (inv_zero_vec && valid) begin nm = BLANK; m_pend_sec = sector_req; m_pend_jdg = judge_req; m_left = DEAD; end
      else if (WD_ON && m_waited >= WD) nm = FLT;
    end else if (m_mode == BLANK) begin
      m_left--;
      if (m_left == 0) begin nm = LOAD; m_sec = m_pend_sec; m_jdg = m_pend_jdg; m_cnt = (m_cnt + 1) % 65536; end
    end else if (m_mode == LOAD) nm = RUN;
    if (nm == WAITZ && m_mode != WAITZ) m_waited = 0;
    m_mode = nm;
  endtask

  task automatic step();
    if (global_rst) model_reset(); else model_step();
    @(posedge sysclk); #1;
  endtask

  task automatic test_reset();
    global_rst = 1; enable = 0; fault_in = 0; fault_clr = 0;
    sector_req = 0; judge_req = 0; inv_zero_vec = 0;
    repeat (3) step();
    global_rst = 0;
    n_chk++; if ({grid_sector, grid_judge, SD, busy, fault, sector_err, comm_cnt} !== 38'd0) $display("FAIL reset_outputs got %h exp 0", {grid_sector, grid_judge, SD, busy, fault, sector_err, comm_cnt}); else n_pass++;
    step();
    n_chk++; if (SD !== 1'b0) $display("FAIL reset_idle_sd got %b exp 0", SD); else n_pass++;
  endtask

  task automatic test_startup();
    enable = 1; sector_req = 3; judge_req = 0; inv_zero_vec = 1;
    step();
    n_chk++; if (SD !== 1'b1) $display("FAIL startup_sd got %b exp 1", SD); else n_pass++;
    n_chk++; if (grid_sector !== 16'd3) $display("FAIL startup_sector got %0d exp 3", grid_sector); else n_pass++;
    n_chk++; if (comm_cnt !== 16'd0 || busy !== 1'b0) $display("FAIL startup_cnt_busy got %0d/%b exp 0/0", comm_cnt, busy); else n_pass++;
  endtask

  task automatic test_commutation();
    int lowc = 0;
    logic [15:0] last_sec = 0;
    sector_req = 4; inv_zero_vec = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if (busy !== 1'b1 || SD !== 1'b1 || grid_sector !== 16'd3) $display("FAIL comm_wait%0d busy/sd/sector got %b/%b/%0d exp 1/1/3", i, busy, SD, grid_sector); else n_pass++;
    end
    inv_zero_vec = 1;
    step();
    n_chk++; if (grid_sector !== 16'd3) $display("FAIL comm_first_blank_sector got %0d exp 3", grid_sector); else n_pass++;
    while (SD === 1'b0 && lowc < 30) begin
      last_sec = grid_sector;
      lowc++;
      step();
    end
    n_chk++; if (lowc != DEAD + 1) $display("FAIL comm_sd_low_cycles got %0d exp %0d", lowc, DEAD + 1); else n_pass++;
    n_chk++; if (last_sec !== 16'd4) $display("FAIL comm_sector_while_low got %0d exp 4", last_sec); else n_pass++;
    n_chk++; if (SD !== 1'b1 || busy !== 1'b0 || comm_cnt !== 16'd1) $display("FAIL comm_done sd/busy/cnt got %b/%b/%0d exp 1/0/1", SD, busy, comm_cnt); else n_pass++;
  endtask

  task automatic test_cancel();
    sector_req = 3; inv_zero_vec = 0;
    step();
    n_chk++; if (busy !== 1'b1 || SD !== 1'b1) $display("FAIL cancel_wait busy/sd got %b/%b exp 1/1", busy, SD); else n_pass++;
    sector_req = 4;
    step();
    n_chk++; if (busy !== 1'b0 || SD !== 1'b1 || comm_cnt !== 16'd1 || grid_sector !== 16'd4) $display("FAIL cancel_back busy/sd/cnt/sector got %b/%b/%0d/%0d exp 0/1/1/4", busy, SD, comm_cnt, grid_sector); else n_pass++;
  endtask

  task automatic test_invalid();
    sector_req = 7;
    step();
    n_chk++; if (sector_err !== 1'b1 || SD !== 1'b1 || busy !== 1'b0 || grid_sector !== 16'd4) $display("FAIL invalid_reject err/sd/busy/sector got %b/%b/%b/%0d exp 1/1/0/4", sector_err, SD, busy, grid_sector); else n_pass++;
    sector_req = 4;
    step();
    n_chk++; if (sector_err !== 1'b0) $display("FAIL invalid_pulse_end got %b exp 0", sector_err); else n_pass++;
  endtask

  task automatic test_fault();
    sector_req = 5; inv_zero_vec = 1;
    repeat (4) step();
    n_chk++; if (SD !== 1'b0 || busy !== 1'b1) $display("FAIL fault_in_blank sd/busy got %b/%b exp 0/1", SD, busy); else n_pass++;
    fault_in = 1;
    step();
    n_chk++; if (fault !== 1'b1 || SD !== 1'b0 || busy !== 1'b0) $display("FAIL fault_enter fault/sd/busy got %b/%b/%b exp 1/0/0", fault, SD, busy); else n_pass++;
    fault_clr = 1;
    step();
    n_chk++; if (fault !== 1'b1) $display("FAIL fault_clr_ignored got %b exp 1", fault); else n_pass++;
    fault_in = 0; fault_clr = 0;
    step();
    n_chk++; if (fault !== 1'b1) $display("FAIL fault_latched got %b exp 1", fault); else n_pass++;
    fault_clr = 1;
    step();
    fault_clr = 0;
    n_chk++; if (fault !== 1'b0 || SD !== 1'b0 || grid_sector !== 16'd4 || comm_cnt !== 16'd1) $display("FAIL fault_cleared fault/sd/sector/cnt got %b/%b/%0d/%0d exp 0/0/4/1", fault, SD, grid_sector, comm_cnt); else n_pass++;
    step();
    n_chk++; if (SD !== 1'b1 || grid_sector !== 16'd5 || comm_cnt !== 16'd1) $display("FAIL restart sd/sector/cnt got %b/%0d/%0d exp 1/5/1", SD, grid_sector, comm_cnt); else n_pass++;
  endtask

  task automatic test_disable();
    enable = 0; sector_req = 2;
    step();
    n_chk++; if (SD !== 1'b0 || grid_sector !== 16'd5) $display("FAIL disable sd/sector got %b/%0d exp 0/5", SD, grid_sector); else n_pass++;
    enable = 1;
    step();
    n_chk++; if (SD !== 1'b1 || grid_sector !== 16'd2) $display("FAIL reenable sd/sector got %b/%0d exp 1/2", SD, grid_sector); else n_pass++;
  endtask

  task automatic test_watchdog();
    sector_req = 6; inv_zero_vec = 0;
    step();
`ifdef RECT_COMM_WATCHDOG_EN
    repeat (WD - 1) step();
    n_chk++; if (fault !== 1'b0 || busy !== 1'b1) $display("FAIL wd_early fault/busy got %b/%b exp 0/1", fault, busy); else n_pass++;
    step();
    n_chk++; if (fault !== 1'b1 || SD !== 1'b0) $display("FAIL wd_trip fault/sd got %b/%b exp 1/0", fault, SD); else n_pass++;
    fault_clr = 1;
    step();
    fault_clr = 0;
`else
    repeat (1000) step();
    n_chk++; if (busy !== 1'b1 || SD !== 1'b1 || fault !== 1'b0) $display("FAIL wd_absent busy/sd/fault got %b/%b/%b exp 1/1/0", busy, SD, fault); else n_pass++;
`endif
    inv_zero_vec = 1;
    repeat (DEAD + 2) step();
  endtask

  task automatic test_reset_mid_blank();
    sector_req = 1; inv_zero_vec = 1;
    repeat (4) step();
    n_chk++; if (SD !== 1'b0 || busy !== 1'b1) $display("FAIL pre_reset_blank sd/busy got %b/%b exp 0/1", SD, busy); else n_pass++;
    #3 global_rst = 1;
    #1;
    n_chk++; if ({grid_sector, grid_judge, SD, busy, fault, sector_err, comm_cnt} !== 38'd0) $display("FAIL async_reset got %h exp 0", {grid_sector, grid_judge, SD, busy, fault, sector_err, comm_cnt}); else n_pass++;
    model_reset();
    @(posedge sysclk); #1;
    global_rst = 0;
  endtask

  task automatic test_random();
    logic [37:0] exp_v, got_v;
    for (int c = 0; c < 4000; c++) begin
      enable     = $urandom_range(0, 99) < 97;
      fault_in   = $urandom_range(0, 99) < 2;
      fault_clr  = $urandom_range(0, 99) < 20;
      inv_zero_vec = $urandom_range(0, 99) < 25;
      if ($urandom_range(0, 99) < 10) sector_req = 16'($urandom_range(0, 8));
      if ($urandom_range(0, 99) < 5) judge_req = ~judge_req;
      step();
      exp_v = {16'(m_sec), m_jdg[0], m_mode == RUN || m_mode == WAITZ,
               m_mode == WAITZ || m_mode == BLANK || m_mode == LOAD, m_mode == FLT, m_err[0], 16'(m_cnt)};
      got_v = {grid_sector, grid_judge, SD, busy, fault, sector_err, comm_cnt};
      n_chk++; if (got_v !== exp_v) $display("FAIL random_cycle%0d got %h exp %h", c, got_v, exp_v); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_commutation();
    test_cancel();
    test_invalid();
    test_fault();
    test_disable();
    test_watchdog();
    test_reset_mid_blank();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rect_commutation_ctrl.md
Name: rect_commutation_ctrl

Overview:
Sequences the rectifier stage of the matrix-converter drive. It owns the rectifier's grid_sector, grid_judge and SD inputs. Sector/judge changes are applied only while the inverter is in a zero vector (zero DC-link current), with a shutdown blanking window around each update. It also handles start-up, disable and fault shutdown of the rectifier switches.

Parameters:
DEAD_CYCLES, 8, sysclk cycles SD is held low before a new sector/judge is loaded (legal range 1..255)
CNT_W, 16, width of the commutation counter
WD_CYCLES, 1000, max sysclk cycles spent waiting for a zero vector (used only with the optional feature)

Ports:
sysclk  in  1  system clock
global_rst  in  1  asynchronous, active-high reset
enable  in  1  run request; low forces shutdown
fault_in  in  1  external fault (overcurrent/overvoltage); level-sensitive
fault_clr  in  1  clears the latched fault
sector_req  in  16  requested grid voltage sector; valid values 1..6
judge_req  in  1  requested duty-control flag
inv_zero_vec  in  1  high while the inverter applies a zero vector
grid_sector  out  16  registered sector to the rectifier
grid_judge  out  1  registered judge to the rectifier
SD  out  1  rectifier enable; low = all switches off
busy  out  1  high in WAIT_ZERO, BLANK and LOAD
fault  out  1  high in FAULT
sector_err  out  1  one-cycle pulse when an invalid sector_req is rejected
comm_cnt  out  CNT_W  completed commutations; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: single clock sysclk. global_rst is asynchronous and active-high.
- Reset values: state OFF, grid_sector=0, grid_judge=0, SD=0, busy=0, fault=0, sector_err=0, comm_cnt=0, dead counter=0.
- All outputs are registered. SD is a decode of the next state, so SD changes on the same edge as the state change.
- Valid sector: sector_req in 1..6. Any other value is never loaded. In RUN and OFF, an invalid request that would otherwise trigger a transition pulses sector_err for 1 cycle, and the state is held.
- OFF (SD=0): if enable=1, fault_in=0, sector_req is valid and inv_zero_vec=1, then load grid_sector/grid_judge from the request, go to RUN, SD=1 on the same edge.
- RUN (SD=1): if the request differs from grid_sector/grid_judge and is valid, go to WAIT_ZERO.
- WAIT_ZERO (SD=1, busy=1):
  - If the request returns to the current outputs, go back to RUN with no commutation.
  - If inv_zero_vec=1, snapshot the request into pending registers, go to BLANK, SD=0 on that edge, and load the dead counter with DEAD_CYCLES.
- BLANK (SD=0): decrement the dead counter each cycle. At 1, go to LOAD. BLANK therefore lasts exactly DEAD_CYCLES cycles. Request changes during BLANK are ignored and taken up after RUN is re-entered.
- LOAD (SD=0, 1 cycle): grid_sector/grid_judge take the pending values, comm_cnt increments, next state RUN with SD=1.
- Latency: from inv_zero_vec sampled high in WAIT_ZERO to SD high again = DEAD_CYCLES+2 edges. grid_sector never changes while SD=1.
- Disable: enable=0 in any non-FAULT state goes to OFF on the next edge (SD=0). grid_sector/grid_judge hold their values and any pending commutation is discarded.
- Fault: fault_in=1 in any state goes to FAULT on the next edge (SD=0, fault=1). Fault has priority over enable and over all other transitions.
- FAULT: leave to OFF only when fault_clr=1 and fault_in=0 in the same cycle. fault_clr while fault_in=1 is ignored.
- Simultaneous events: fault > disable > commutation.
- comm_cnt wraps to 0 after all-ones, with no flag.
- Reset asserted mid-BLANK or mid-LOAD: immediate return to reset values; pending registers are cleared.

Optional Feature:
Macro RECT_COMM_WATCHDOG_EN.
- Defined: a wait counter clears on entry to WAIT_ZERO and increments each cycle spent there. If it reaches WD_CYCLES without a zero vector, the block goes to FAULT (SD=0, fault=1) exactly as for fault_in, with the same clear rule.
- Undefined: WAIT_ZERO waits indefinitely, no wait counter is synthesised, and WD_CYCLES is unused.

Test Plan:
- Start-up: reset, then enable=1, sector_req=3, judge_req=0, inv_zero_vec=1 -> next edge state RUN, grid_sector=3, SD=1, comm_cnt=0.
- Commutation: in RUN with sector 3, sector_req=4, inv_zero_vec low for 5 cycles then high -> busy for 5 cycles with SD=1; then SD=0 for DEAD_CYCLES+1=9 cycles; grid_sector=4 while SD=0; SD=1 at the edge after LOAD; comm_cnt=1.
- Cancel: in WAIT_ZERO from 3 to 4, sector_req returns to 3 before inv_zero_vec -> back to RUN, SD never drops, comm_cnt unchanged.
- Invalid sector: in RUN, sector_req=7 -> sector_err high for 1 cycle, state RUN, grid_sector unchanged, SD=1.
- Fault mid-BLANK: fault_in=1 during BLANK -> FAULT, SD=0, fault=1. fault_clr=1 while fault_in=1 -> stays in FAULT. Drop fault_in, then fault_clr=1 -> OFF, fault=0.
- Watchdog (RECT_COMM_WATCHDOG_EN, WD_CYCLES=20): request change with inv_zero_vec held low -> FAULT exactly 20 cycles after entering WAIT_ZERO, SD=0. With the macro undefined -> still in WAIT_ZERO after 1000 cycles.
